// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: assembles serial fetch beats into words, buffers two
// of them for the decoder and feeds the immediate shifter from the head or next word.
module inst_prefetch_queue #(
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    output logic                  fetch_req,
    input  logic                  fetch_start,
    input  logic                  fetch_data_valid,
    input  logic [NSHIFT-1:0]     fetch_data,
    output logic                  inst_valid,
    output logic [2*REG_BITS-1:0] inst,
    input  logic                  inst_done,
    input  logic                  load_imm16,
    output logic                  imm16_loaded,
    output logic [2*REG_BITS-1:0] imm_full,
    output logic [NSHIFT-1:0]     imm_data_in,
    input  logic                  next_imm_data
);
    localparam int W     = 2 * REG_BITS;
    localparam int BEATS = W / NSHIFT;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    // Handshakes: a word transfer begins with fetch_start, which is only legal while
    // fetch_req=1; the head word is offered while inst_valid=1 and retired by inst_done.
    logic [1:0]        r_count;
    logic [W-1:0]      r_e0;
    logic [W-1:0]      r_e1;
    logic [W-1:0]      r_asm;
    logic [BW-1:0]     r_bcnt;
    logic              r_busy;
    logic [W-1:0]      r_imm_sr;
    logic [W-1:0]      r_imm_hold;
    logic              r_loaded;

    logic              w_beat;
    logic              w_push;
    logic              w_pop;
    logic              w_ld;
    logic [W-1:0]      w_word;
    logic [1:0]        w_count_nxt;
    logic [W-1:0]      w_e0_nxt;
    logic [W-1:0]      w_e1_nxt;
    logic              w_new_head;

    assign w_beat = fetch_data_valid && r_busy;
    assign w_push = w_beat && (r_bcnt == LAST_BEAT);
    assign w_word = {fetch_data, r_asm[W-1:NSHIFT]};
    assign w_pop  = inst_done && (r_count != 2'd0);
    // inst_done takes precedence so the word behind the head is never stolen twice
    assign w_ld   = load_imm16 && (r_count == 2'd2) && !r_loaded && !inst_done;

    always_comb begin
        w_count_nxt = r_count;
        w_e0_nxt    = r_e0;
        w_e1_nxt    = r_e1;
        w_new_head  = 1'b0;
        case ({w_push, w_pop})
            2'b10: begin
                if (r_count == 2'd0) begin
                    w_e0_nxt    = w_word;
                    w_count_nxt = 2'd1;
                    w_new_head  = 1'b1;
                end else begin
                    w_e1_nxt    = w_word;
                    w_count_nxt = 2'd2;
                end
            end
            2'b01: begin
                w_e0_nxt    = r_e1;
                w_count_nxt = r_count - 2'd1;
                w_new_head  = (r_count == 2'd2);
            end
            2'b11: begin
                w_new_head = 1'b1;
                if (r_count == 2'd1) begin
                    w_e0_nxt = w_word;
                end else begin
                    w_e0_nxt = r_e1;
                    w_e1_nxt = w_word;
                end
            end
            default: ;
        endcase
        if (w_ld) begin
            w_count_nxt = 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= 2'd0;
            r_e0       <= '0;
            r_e1       <= '0;
            r_asm      <= '0;
            r_bcnt     <= '0;
            r_busy     <= 1'b0;
            r_imm_sr   <= '0;
            r_imm_hold <= '0;
            r_loaded   <= 1'b0;
        end else if (flush) begin
            r_count  <= 2'd0;
            r_busy   <= 1'b0;
            r_bcnt   <= '0;
            r_loaded <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_e0     <= w_e0_nxt;
            r_e1     <= w_e1_nxt;
            r_loaded <= w_ld;
            if (fetch_start) begin
                r_busy <= 1'b1;
                r_bcnt <= '0;
            end else if (w_beat) begin
                r_asm <= w_word;
                if (w_push) begin
                    r_busy <= 1'b0;
                    r_bcnt <= '0;
                end else begin
                    r_bcnt <= r_bcnt + 1'b1;
                end
            end
            // A fresh head preloads the shifter so short immediates stream from the opcode word
            if (w_new_head) begin
                r_imm_sr   <= w_e0_nxt;
                r_imm_hold <= w_e0_nxt;
            end else if (w_ld) begin
                r_imm_sr   <= r_e1;
                r_imm_hold <= r_e1;
            end else if (next_imm_data) begin
                r_imm_sr <= r_imm_sr >> NSHIFT;
            end
        end
    end

    assign fetch_req    = !r_busy && (r_count != 2'd2);
    assign inst_valid   = (r_count != 2'd0);
    assign inst         = r_e0;
    assign imm16_loaded = r_loaded;
    assign imm_full     = r_imm_hold;
    assign imm_data_in  = r_imm_sr[NSHIFT-1:0];

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed scenarios plus a randomized run checked
// against a word-level queue model of the prefetch buffer and immediate shifter.
module tb_inst_prefetch_queue;
    localparam int W      = 16;
    localparam int NSHIFT = 2;
    localparam int BEATS  = W / NSHIFT;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              fetch_req;
    logic              fetch_start;
    logic              fetch_data_valid;
    logic [NSHIFT-1:0] fetch_data;
    logic              inst_valid;
    logic [W-1:0]      inst;
    logic              inst_done;
    logic              load_imm16;
    logic              imm16_loaded;
    logic [W-1:0]      imm_full;
    logic [NSHIFT-1:0] imm_data_in;
    logic              next_imm_data;

    int errors = 0;
    int checks = 0;

    // Reference model: buffered words, word in flight, immediate shifter contents
    logic [W-1:0] exp_q[$];
    bit           m_busy;
    int           m_beats;
    logic [W-1:0] m_acc;
    logic [W-1:0] m_imm_sr;
    logic [W-1:0] m_imm_hold;
    bit           m_loaded;

    inst_prefetch_queue #(.REG_BITS(8), .NSHIFT(NSHIFT)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .fetch_req        (fetch_req),
        .fetch_start      (fetch_start),
        .fetch_data_valid (fetch_data_valid),
        .fetch_data       (fetch_data),
        .inst_valid       (inst_valid),
        .inst             (inst),
        .inst_done        (inst_done),
        .load_imm16       (load_imm16),
        .imm16_loaded     (imm16_loaded),
        .imm_full         (imm_full),
        .imm_data_in      (imm_data_in),
        .next_imm_data    (next_imm_data)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        if (!reset && fetch_start && !fetch_req) begin
            errors++;
            $display("FAIL protocol_start: fetch_start while fetch_req=0");
        end
        if (!reset && inst_done && !inst_valid) begin
            errors++;
            $display("FAIL protocol_done: inst_done while inst_valid=0");
        end
    end

    // ---------------- model ----------------
    function automatic void model_reset();
        exp_q.delete();
        m_busy     = 0;
        m_beats    = 0;
        m_acc      = '0;
        m_imm_sr   = '0;
        m_imm_hold = '0;
        m_loaded   = 0;
    endfunction

    function automatic void model_step();
        int           n0;
        bit           pop;
        bit           ld;
        bit           push;
        bit           head_chg;
        logic [W-1:0] w;
        logic [W-1:0] ld_word;
        if (flush) begin
            exp_q.delete();
            m_busy   = 0;
            m_beats  = 0;
            m_loaded = 0;
            return;
        end
        n0      = exp_q.size();
        pop     = inst_done && (n0 > 0);
        ld      = load_imm16 && (n0 == 2) && !m_loaded && !inst_done;
        push    = 0;
        w       = '0;
        ld_word = '0;
        if (fetch_start) begin
            m_busy  = 1;
            m_beats = 0;
            m_acc   = '0;
        end else if (fetch_data_valid && m_busy) begin
            m_acc = m_acc | (W'(fetch_data) << (NSHIFT * m_beats));
            m_beats++;
            if (m_beats == BEATS) begin
                push    = 1;
                w       = m_acc;
                m_busy  = 0;
                m_beats = 0;
            end
        end
        if (ld) begin
            ld_word = exp_q[1];
            exp_q.delete(1);
        end
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back(w);
        head_chg = (pop && exp_q.size() > 0) || (push && n0 == 0);
        if (head_chg) begin
            m_imm_sr   = exp_q[0];
            m_imm_hold = exp_q[0];
        end else if (ld) begin
            m_imm_sr   = ld_word;
            m_imm_hold = ld_word;
        end else if (next_imm_data) begin
            m_imm_sr = m_imm_sr >> NSHIFT;
        end
        m_loaded = ld;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic start_word();
        int n = 0;
        while (!fetch_req && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!fetch_req) begin
            errors++;
            $display("FAIL start_wait: fetch_req=%0b after %0d cycles, need 1", fetch_req, n);
        end else begin
            fetch_start = 1'b1;
            tick();
            fetch_start = 1'b0;
        end
    endtask

    task automatic drive_beats(input logic [W-1:0] v, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            fetch_data_valid = 1'b1;
            fetch_data       = v[NSHIFT*i +: NSHIFT];
            tick();
        end
        fetch_data_valid = 1'b0;
        fetch_data       = '0;
    endtask

    task automatic send_word(input logic [W-1:0] v);
        start_word();
        drive_beats(v, 0, BEATS);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        flush = 0; fetch_start = 0; fetch_data_valid = 0; fetch_data = '0;
        inst_done = 0; load_imm16 = 0; next_imm_data = 0;
        repeat (2) @(negedge clk);
        model_reset();
        checks += 5;
        if (fetch_req !== 1'b1) begin errors++; $display("FAIL reset_fetch_req: got %0b need 1", fetch_req); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %0b need 0", inst_valid); end
        if (imm16_loaded !== 1'b0) begin errors++; $display("FAIL reset_imm16_loaded: got %0b need 0", imm16_loaded); end
        if (imm_full !== 16'h0) begin errors++; $display("FAIL reset_imm_full: got %h need 0000", imm_full); end
        if (imm_data_in !== 2'd0) begin errors++; $display("FAIL reset_imm_data_in: got %0d need 0", imm_data_in); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        start_word();
        drive_beats(16'h2A41, 0, BEATS - 1);
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b need 0", inst_valid); end
        drive_beats(16'h2A41, BEATS - 1, 1);
        checks += 5;
        if (inst_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b need 1", inst_valid); end
        if (inst !== 16'h2A41) begin errors++; $display("FAIL single_inst: got %h need 2a41", inst); end
        if (imm_data_in !== 2'd1) begin errors++; $display("FAIL single_imm_data_in: got %0d need 1", imm_data_in); end
        if (imm_full !== 16'h2A41) begin errors++; $display("FAIL single_imm_full: got %h need 2a41", imm_full); end
        if (fetch_req !== 1'b1) begin errors++; $display("FAIL single_fetch_req: got %0b need 1", fetch_req); end
    endtask

    task automatic test_fill();
        do_flush();
        send_word(16'h1234);
        send_word(16'hBEEF);
        checks += 3;
        if (fetch_req !== 1'b0) begin errors++; $display("FAIL fill_fetch_req_full: got %0b need 0", fetch_req); end
        if (inst !== 16'h1234) begin errors++; $display("FAIL fill_head: got %h need 1234", inst); end
        if (imm_full !== 16'h1234) begin errors++; $display("FAIL fill_imm_full: got %h need 1234", imm_full); end
        inst_done = 1'b1;
        tick();
        inst_done = 1'b0;
        checks += 3;
        if (inst !== 16'hBEEF) begin errors++; $display("FAIL fill_pop_inst: got %h need beef", inst); end
        if (imm_full !== 16'hBEEF) begin errors++; $display("FAIL fill_pop_imm_full: got %h need beef", imm_full); end
        if (fetch_req !== 1'b1) begin errors++; $display("FAIL fill_pop_fetch_req: got %0b need 1", fetch_req); end
    endtask

    task automatic test_imm16();
        logic [W-1:0] v = 16'hABCD;
        logic [W-1:0] sh;
        do_flush();
        send_word(16'h1001);
        send_word(v);
        load_imm16 = 1'b1;
        tick();
        checks += 3;
        if (imm16_loaded !== 1'b1) begin errors++; $display("FAIL imm16_pulse: got %0b need 1", imm16_loaded); end
        if (imm_full !== 16'hABCD) begin errors++; $display("FAIL imm16_full: got %h need abcd", imm_full); end
        if (imm_data_in !== 2'd1) begin errors++; $display("FAIL imm16_low: got %0d need 1", imm_data_in); end
        tick();
        load_imm16 = 1'b0;
        checks++;
        if (imm16_loaded !== 1'b0) begin errors++; $display("FAIL imm16_single_pulse: got %0b need 0", imm16_loaded); end
        for (int k = 1; k <= 4; k++) begin
            next_imm_data = 1'b1;
            tick();
            sh = v >> (NSHIFT * k);
            checks++;
            if (imm_data_in !== sh[NSHIFT-1:0]) begin
                errors++;
                $display("FAIL imm16_shift%0d: got %0d need %0d", k, imm_data_in, sh[NSHIFT-1:0]);
            end
        end
        next_imm_data = 1'b0;
        checks += 2;
        if (inst !== 16'h1001) begin errors++; $display("FAIL imm16_head_kept: got %h need 1001", inst); end
        if (imm_full !== 16'hABCD) begin errors++; $display("FAIL imm16_full_kept: got %h need abcd", imm_full); end
    endtask

    task automatic test_imm16_wait();
        do_flush();
        send_word(16'h7777);
        load_imm16 = 1'b1;
        send_word(16'h00FF);
        checks++;
        if (imm16_loaded !== 1'b0) begin errors++; $display("FAIL wait_no_bypass: got %0b need 0", imm16_loaded); end
        tick();
        checks += 3;
        if (imm16_loaded !== 1'b1) begin errors++; $display("FAIL wait_pulse: got %0b need 1", imm16_loaded); end
        if (imm_full !== 16'h00FF) begin errors++; $display("FAIL wait_imm_full: got %h need 00ff", imm_full); end
        if (inst !== 16'h7777) begin errors++; $display("FAIL wait_head: got %h need 7777", inst); end
        tick();
        load_imm16 = 1'b0;
        checks++;
        if (imm16_loaded !== 1'b0) begin errors++; $display("FAIL wait_pulse_end: got %0b need 0", imm16_loaded); end
    endtask

    task automatic test_flush_mid();
        do_flush();
        send_word(16'h3C3C);
        start_word();
        drive_beats(16'h9999, 0, 3);
        do_flush();
        checks += 2;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b need 0", inst_valid); end
        if (fetch_req !== 1'b1) begin errors++; $display("FAIL flush_fetch_req: got %0b need 1", fetch_req); end
        drive_beats(16'h9999, 3, 5);
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL flush_stale_beats: got %0b need 0", inst_valid); end
        send_word(16'h5555);
        checks += 2;
        if (inst !== 16'h5555 || inst_valid !== 1'b1) begin
            errors++; $display("FAIL flush_refill: got %h/%0b need 5555/1", inst, inst_valid);
        end
        if (imm_full !== 16'h5555) begin errors++; $display("FAIL flush_refill_imm: got %h need 5555", imm_full); end
        flush = 1'b1;
        fetch_start = 1'b1;
        tick();
        flush = 1'b0;
        fetch_start = 1'b0;
        drive_beats(16'hF0F0, 0, BEATS);
        checks += 2;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL flush_start_drop: got %0b need 0", inst_valid); end
        if (imm_full !== 16'h5555) begin errors++; $display("FAIL flush_imm_kept: got %h need 5555", imm_full); end
    endtask

    task automatic test_done_on_last();
        do_flush();
        send_word(16'h1111);
        start_word();
        drive_beats(16'h2222, 0, BEATS - 1);
        inst_done = 1'b1;
        drive_beats(16'h2222, BEATS - 1, 1);
        inst_done = 1'b0;
        checks += 4;
        if (inst_valid !== 1'b1) begin errors++; $display("FAIL last_done_valid: got %0b need 1", inst_valid); end
        if (inst !== 16'h2222) begin errors++; $display("FAIL last_done_inst: got %h need 2222", inst); end
        if (imm_full !== 16'h2222) begin errors++; $display("FAIL last_done_imm: got %h need 2222", imm_full); end
        if (fetch_req !== 1'b1) begin errors++; $display("FAIL last_done_fetch_req: got %0b need 1", fetch_req); end
        inst_done = 1'b1;
        tick();
        inst_done = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL last_done_count1: got %0b need 0", inst_valid); end
    endtask

    task automatic test_done_with_load();
        do_flush();
        send_word(16'h4321);
        send_word(16'h8765);
        load_imm16 = 1'b1;
        inst_done  = 1'b1;
        tick();
        inst_done = 1'b0;
        checks += 2;
        if (inst !== 16'h8765) begin errors++; $display("FAIL done_ld_inst: got %h need 8765", inst); end
        if (imm_full !== 16'h8765) begin errors++; $display("FAIL done_ld_imm: got %h need 8765", imm_full); end
        tick();
        load_imm16 = 1'b0;
        checks++;
        if (imm16_loaded !== 1'b0) begin errors++; $display("FAIL done_ld_no_pulse: got %0b need 0", imm16_loaded); end
    endtask

    task automatic test_random();
        bit hold_ld = 0;
        for (int c = 0; c < 3000; c++) begin
            fetch_start      = fetch_req && ($urandom_range(0, 3) == 0);
            fetch_data_valid = ($urandom_range(0, 3) != 0);
            fetch_data       = NSHIFT'($urandom_range(0, (1 << NSHIFT) - 1));
            inst_done        = inst_valid && ($urandom_range(0, 4) == 0);
            if (!hold_ld && $urandom_range(0, 7) == 0) hold_ld = 1;
            load_imm16       = hold_ld;
            next_imm_data    = ($urandom_range(0, 2) == 0);
            flush            = ($urandom_range(0, 60) == 0);
            tick();
            checks += 5;
            if (inst_valid !== (exp_q.size() > 0)) begin
                errors++; $display("FAIL rnd_inst_valid c=%0d: got %0b need %0b", c, inst_valid, exp_q.size() > 0);
            end else if (inst_valid && inst !== exp_q[0]) begin
                errors++; $display("FAIL rnd_inst c=%0d: got %h need %h", c, inst, exp_q[0]);
            end
            if (fetch_req !== (!m_busy && exp_q.size() < 2)) begin
                errors++; $display("FAIL rnd_fetch_req c=%0d: got %0b", c, fetch_req);
            end
            if (imm16_loaded !== m_loaded) begin
                errors++; $display("FAIL rnd_imm16_loaded c=%0d: got %0b need %0b", c, imm16_loaded, m_loaded);
            end
            if (imm_full !== m_imm_hold) begin
                errors++; $display("FAIL rnd_imm_full c=%0d: got %h need %h", c, imm_full, m_imm_hold);
            end
            if (imm_data_in !== m_imm_sr[NSHIFT-1:0]) begin
                errors++; $display("FAIL rnd_imm_data_in c=%0d: got %0d need %0d", c, imm_data_in, m_imm_sr[NSHIFT-1:0]);
            end
            if (imm16_loaded) hold_ld = 0;
        end
        fetch_start = 0; fetch_data_valid = 0; inst_done = 0;
        load_imm16 = 0; next_imm_data = 0; flush = 0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_word();
        test_fill();
        test_imm16();
        test_imm16_wait();
        test_flush_mid();
        test_done_on_last();
        test_done_with_load();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
